// File: rtl/msg_queue_drain.sv
// Polls a shared-memory outbound message queue and drains every word between the
// read and write pointers to a valid/ready sink, then writes back the read pointer once.
module msg_queue_drain #(
    parameter int QUEUE_ADDR_BITS = 10,
    parameter int POLL_INTERVAL   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        kick,
    output logic [31:0] mem_addr,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int          PW        = QUEUE_ADDR_BITS - 1;
    localparam int          QSZ       = 1 << PW;
    localparam logic [31:0] RP_ADDR   = 32'd2;
    localparam logic [31:0] WP_ADDR   = 32'd3;
    localparam logic [31:0] SLOT_BASE = 32'(32'h400 + QSZ);
    localparam logic [16:0] POLL_LIM  = 17'(POLL_INTERVAL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WP,
        S_RD_RP,
        S_CMP,
        S_RD_DAT,
        S_CAP,
        S_OUT,
        S_WB
    } state_t;

    state_t          r_state;
    logic [15:0]     r_timer;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;

    logic [PW-1:0]   w_ptr_rd_data;
    logic [PW-1:0]   w_rd_next;
    logic            w_xfer;
    logic            w_timer_done;
    logic            w_poll_go;

    function automatic logic [31:0] slot_addr(input logic [PW-1:0] idx);
        return SLOT_BASE + 32'(idx);
    endfunction

    // Pointer words carry garbage above the queue index width; only the low bits matter.
    assign w_ptr_rd_data = mem_read_data[PW-1:0];
    assign w_rd_next     = r_rd + 1'b1;
    assign w_xfer        = out_valid && out_ready;
    assign w_timer_done  = ({1'b0, r_timer} + 17'd1) >= POLL_LIM;
    assign w_poll_go     = enable && (kick || w_timer_done);

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_rd           <= '0;
            r_wr           <= '0;
            mem_addr       <= '0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_write_data <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
        end else begin
            // Strobes are one-cycle pulses unless a state re-arms them.
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!enable) begin
                        r_timer <= '0;
                    end else if (w_poll_go) begin
                        r_timer     <= '0;
                        mem_read_en <= 1'b1;
                        mem_addr    <= WP_ADDR;
                        r_state     <= S_RD_WP;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                S_RD_WP: begin
                    mem_read_en <= 1'b1;
                    mem_addr    <= RP_ADDR;
                    r_state     <= S_RD_RP;
                end

                S_RD_RP: begin
                    r_wr    <= w_ptr_rd_data;
                    r_state <= S_CMP;
                end

                S_CMP: begin
                    r_rd <= w_ptr_rd_data;
                    if (w_ptr_rd_data == r_wr) begin
                        r_state <= S_IDLE;
                    end else begin
                        mem_read_en <= 1'b1;
                        mem_addr    <= slot_addr(w_ptr_rd_data);
                        r_state     <= S_RD_DAT;
                    end
                end

                S_RD_DAT: begin
                    r_state <= S_CAP;
                end

                S_CAP: begin
                    out_data  <= mem_read_data;
                    out_valid <= 1'b1;
                    r_state   <= S_OUT;
                end

                S_OUT: begin
                    if (w_xfer) begin
                        out_valid <= 1'b0;
                        r_rd      <= w_rd_next;
                        // Stop at the write-pointer snapshot; later producer words wait for the next poll.
                        if (w_rd_next != r_wr) begin
                            mem_read_en <= 1'b1;
                            mem_addr    <= slot_addr(w_rd_next);
                            r_state     <= S_RD_DAT;
                        end else begin
                            mem_write_en   <= 1'b1;
                            mem_addr       <= RP_ADDR;
                            mem_write_data <= 32'(w_rd_next);
                            r_state        <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/msg_queue_drain.md
MSG_QUEUE_DRAIN -- requirements
Module: msg_queue_drain

Interface
REQ-001 Parameter QUEUE_ADDR_BITS, default 10: total queue words are 2**QUEUE_ADDR_BITS; each direction holds QSZ = 2**(QUEUE_ADDR_BITS-1) words.
REQ-002 Parameter POLL_INTERVAL, default 16: idle cycles between pointer polls, range 1..65535.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  polling permitted while high.
REQ-006 kick  input  1  single-cycle pulse; forces an immediate poll from IDLE.
REQ-007 mem_addr  output  32  word address to the message-queue memory port.
REQ-008 mem_read_en  output  1  read strobe; data returns on mem_read_data exactly one cycle later.
REQ-009 mem_write_en  output  1  write strobe.
REQ-010 mem_write_data  output  32  write data.
REQ-011 mem_read_data  input  32  read data, valid the cycle after mem_read_en.
REQ-012 out_data  output  32  drained message word.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  sink accepts; transfer when out_valid and out_ready are both high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Memory map: word 2 = outbound_rd_ptr, word 3 = outbound_wr_ptr, outbound slot i at word 'h400 + QSZ + i.
REQ-017 Pointers use the low QUEUE_ADDR_BITS-1 bits; upper bits read back are ignored; written pointer has zero upper bits.
REQ-018 Never assert mem_read_en and mem_write_en in the same cycle; both strobes are single-cycle.
REQ-019 States: IDLE, RD_WP, RD_RP, CMP, RD_DAT, CAP, OUT, WB.
REQ-020 IDLE: 16-bit poll timer counts while enable=1; on reaching POLL_INTERVAL, or kick=1 with enable=1, timer clears -> RD_WP. Timer holds at 0 while enable=0.
REQ-021 RD_WP: read word 3 (one cycle); RD_RP: capture wr snapshot, read word 2; CMP: capture rd copy.
REQ-022 CMP: rd==wr (empty) -> IDLE, no write; otherwise -> RD_DAT.
REQ-023 RD_DAT: read slot rd (one cycle) -> CAP; CAP: latch mem_read_data into out_data, assert out_valid -> OUT.
REQ-024 OUT: hold out_data and out_valid stable until transfer; on transfer rd = (rd+1) mod QSZ; if new rd != wr snapshot -> RD_DAT, else -> WB.
REQ-025 WB: write rd to word 2 (one cycle) -> IDLE; exactly one pointer write per non-empty batch.
REQ-026 Words written by the producer after the wr snapshot are not drained in that batch; they are picked up on the next poll.
REQ-027 Wrap: rd at QSZ-1 increments to 0; slot address wraps accordingly.
REQ-028 Full queue (wr == rd-1 mod QSZ) drains QSZ-1 words in one batch.
REQ-029 enable falling mid-batch does not abort; batch completes through WB, then IDLE holds.
REQ-030 kick outside IDLE is ignored.
REQ-031 Minimum throughput: one word per 3 cycles with out_ready held high.

Reset
REQ-032 On rst: state IDLE, timer 0, rd/wr copies 0, out_valid 0, out_data 0, mem_read_en 0, mem_write_en 0, mem_addr 0, mem_write_data 0, busy 0.
REQ-033 Reset mid-batch discards the local rd copy and performs no pointer write; next poll re-reads both pointers.

Verification
REQ-034 Empty: rd=wr=5, kick -> reads of words 3 then 2, no out_valid, no write, IDLE after CMP.
REQ-035 Three words: rd=0, wr=3, slots 'hA,'hB,'hC, out_ready=1 -> out_data A,B,C in order, then single write of 3 to word 2.
REQ-036 Wrap (QUEUE_ADDR_BITS=10, QSZ=512): rd=510, wr=1 -> slots 510,511,0 emitted (addresses 'h7FE,'h7FF,'h600), write of 1 to word 2.
REQ-037 Backpressure: out_ready low 10 cycles on first word -> out_data and out_valid stable all 10 cycles, no memory access meanwhile.
REQ-038 Polling: enable=1, empty queue, POLL_INTERVAL=4 -> pointer read pair every poll period; enable=0 -> no memory accesses.
REQ-039 Reset asserted in OUT -> all outputs 0 asynchronously; after release and kick, batch restarts from memory-held rd, no prior write.
